// File: rtl/id_hazard_ctrl_if.sv
// Pipeline-side bundle for the ID-stage hazard controller: stage operands in,
// forwarding selects, stall/freeze controls and observability out.
interface id_hazard_ctrl_if;
  logic        ID_Valid;
  logic [4:0]  ID_RegA;
  logic [4:0]  ID_RegB;
  logic        ID_UsesA;
  logic        ID_UsesB;
  logic        ID_Syscall;
  logic [4:0]  EXE_WriteReg;
  logic        EXE_RegWrite;
  logic        EXE_MemRead;
  logic [4:0]  MEM_WriteReg;
  logic        MEM_RegWrite;
  logic [1:0]  Forward_A;
  logic [1:0]  Forward_B;
  logic        STALL;
  logic        FREEZE;
  logic        SYS;
  logic [1:0]  STATE;
  logic [15:0] STALL_CYCLES;

  modport master (
    output ID_Valid, ID_RegA, ID_RegB, ID_UsesA, ID_UsesB, ID_Syscall,
    output EXE_WriteReg, EXE_RegWrite, EXE_MemRead, MEM_WriteReg, MEM_RegWrite,
    input  Forward_A, Forward_B, STALL, FREEZE, SYS, STATE, STALL_CYCLES
  );

  modport slave (
    input  ID_Valid, ID_RegA, ID_RegB, ID_UsesA, ID_UsesB, ID_Syscall,
    input  EXE_WriteReg, EXE_RegWrite, EXE_MemRead, MEM_WriteReg, MEM_RegWrite,
    output Forward_A, Forward_B, STALL, FREEZE, SYS, STATE, STALL_CYCLES
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard unit: operand forwarding selects, one-cycle load-use stall,
// and a drain/syscall/release sequence that freezes fetch around a syscall.
module id_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4
) (
  input logic             CLK,
  input logic             RESET,
  id_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    SYSC    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  logic        sys_reg;
  logic [1:0]  fwd_a_reg;
  logic [1:0]  fwd_b_reg;
  logic [15:0] stall_cnt_reg;

  logic [4:0]  src [2];
  logic [1:0]  uses;
  logic [1:0]  hit_e;
  logic [1:0]  hit_m;
  logic [1:0]  fwd_next [2];
  logic        loaduse;
  logic        syscall_id;
  logic        stall_c;
  logic        freeze_c;

  assign src[0] = bus.ID_RegA;
  assign src[1] = bus.ID_RegB;
  assign uses   = {bus.ID_UsesB, bus.ID_UsesA};

  // ID_Valid gates every term first so undefined operands of a bubble never leak.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_op
      logic live;
      assign live         = bus.ID_Valid & uses[gi] & (src[gi] != 5'd0);
      assign hit_e[gi]    = live & bus.EXE_RegWrite & (bus.EXE_WriteReg == src[gi]);
      assign hit_m[gi]    = live & bus.MEM_RegWrite & (bus.MEM_WriteReg == src[gi]);
      assign fwd_next[gi] = hit_e[gi] ? 2'b01 : (hit_m[gi] ? 2'b10 : 2'b00);
    end
  endgenerate

  assign loaduse    = (|hit_e) & bus.EXE_MemRead;
  assign syscall_id = bus.ID_Valid & bus.ID_Syscall;

  always_comb begin
    stall_c  = 1'b0;
    freeze_c = 1'b0;
    case (state_reg)
      RUN: begin
        stall_c  = loaduse | syscall_id;
        freeze_c = syscall_id;
      end
      DRAIN, SYSC: begin
        stall_c  = 1'b1;
        freeze_c = 1'b1;
      end
      RELEASE: begin
        stall_c  = 1'b0;
        freeze_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= RUN;
      cnt_reg       <= 3'd0;
      sys_reg       <= 1'b0;
      fwd_a_reg     <= 2'b00;
      fwd_b_reg     <= 2'b00;
      stall_cnt_reg <= 16'd0;
    end else begin
      // A stalled edge launches a NOP into EXE, which must not forward.
      if (stall_c) begin
        fwd_a_reg <= 2'b00;
        fwd_b_reg <= 2'b00;
        if (stall_cnt_reg != 16'hFFFF)
          stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end else begin
        fwd_a_reg <= fwd_next[0];
        fwd_b_reg <= fwd_next[1];
      end

      case (state_reg)
        RUN: begin
          if (syscall_id) begin
            state_reg <= DRAIN;
            cnt_reg   <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (cnt_reg != 3'd0) begin
            cnt_reg <= cnt_reg - 3'd1;
          end else begin
            state_reg <= SYSC;
            sys_reg   <= 1'b1;
          end
        end
        SYSC: begin
          state_reg <= RELEASE;
          sys_reg   <= 1'b0;
        end
        RELEASE: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

  assign bus.STALL        = stall_c;
  assign bus.FREEZE       = freeze_c;
  assign bus.SYS          = sys_reg;
  assign bus.STATE        = state_reg;
  assign bus.Forward_A    = fwd_a_reg;
  assign bus.Forward_B    = fwd_b_reg;
  assign bus.STALL_CYCLES = stall_cnt_reg;

endmodule
